// File: rtl/b2h_frame_serializer.sv
// Breakout-to-host frame serializer: snapshots N_LANES x WORD_W bits per frame and
// shifts each lane out MSB-first behind a sync header. Optional CRC-8 trailer: B2H_CRC_EN.
module b2h_frame_serializer #(
  parameter int unsigned N_LANES = 2,
  parameter int unsigned WORD_W  = 12,
  parameter int unsigned SYNC_W  = 4,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1010
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_en,
  input  logic [N_LANES*WORD_W-1:0]   i_word,
  output logic                        o_sample,
  output logic                        o_clk_s,
  output logic                        o_frame_s,
  output logic [N_LANES-1:0]          o_d_s,
  output logic [15:0]                 o_frame_cnt
);

`ifdef B2H_CRC_EN
  localparam int unsigned CRC_W = 8;
`else
  localparam int unsigned CRC_W = 0;
`endif
  localparam int unsigned L     = SYNC_W + WORD_W + CRC_W;
  localparam int unsigned CNT_W = $clog2(L);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_CRC} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_W-1:0]     shift_q [N_LANES];
  logic [WORD_W-1:0]     shift_d [N_LANES];
  logic [SYNC_W-1:0]     sync_q, sync_d;
  logic [N_LANES-1:0]    d_q, d_d;
  logic                  frame_q, frame_d;
  logic                  sample_q, sample_d;
  logic                  last_q, last_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  frame_end_c;
  logic                  latch_c;
`ifdef B2H_CRC_EN
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_W - 1);
  logic [7:0]            crc_q [N_LANES];
  logic [7:0]            crc_d [N_LANES];

  assign frame_end_c = (state_q == S_CRC) && (cnt_q == CRC_LAST);
`else
  assign frame_end_c = (state_q == S_DATA) && (cnt_q == DATA_LAST);
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; run enable is only looked at on frame boundaries
  always_comb begin
    state_d = state_q;
    if (frame_end_c) begin
      state_d = i_en ? S_SYNC : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (i_en) state_d = S_SYNC;
        S_SYNC: if (cnt_q == SYNC_LAST) state_d = S_DATA;
`ifdef B2H_CRC_EN
        S_DATA: if (cnt_q == DATA_LAST) state_d = S_CRC;
        S_CRC:  state_d = S_CRC;
`else
        S_DATA: state_d = S_DATA;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign latch_c = (state_d == S_SYNC) && ((state_q == S_IDLE) || frame_end_c);

  // Output / datapath next values; lanes lag the state by one register stage
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    shift_d     = shift_q;
    sync_d      = sync_q;
    d_d         = '0;
    frame_d     = 1'b0;
    sample_d    = 1'b0;
    last_d      = frame_end_c;
    frame_cnt_d = frame_cnt_q;
`ifdef B2H_CRC_EN
    crc_d       = crc_q;
`endif
    if (last_q) frame_cnt_d = frame_cnt_q + 16'd1;
    if ((state_d != state_q) || frame_end_c) cnt_d = '0;

    case (state_q)
      S_SYNC: begin
        d_d     = {N_LANES{sync_q[SYNC_W-1]}};
        frame_d = 1'b1;
        sync_d  = sync_q << 1;
      end
      S_DATA: begin
        for (int k = 0; k < N_LANES; k++) begin
          d_d[k]     = shift_q[k][WORD_W-1];
          shift_d[k] = shift_q[k] << 1;
`ifdef B2H_CRC_EN
          crc_d[k] = {crc_q[k][6:0], 1'b0}
                   ^ ((crc_q[k][7] ^ shift_q[k][WORD_W-1]) ? 8'h07 : 8'h00);
`endif
        end
      end
`ifdef B2H_CRC_EN
      S_CRC: begin
        for (int k = 0; k < N_LANES; k++) begin
          d_d[k]   = crc_q[k][7];
          crc_d[k] = crc_q[k] << 1;
        end
      end
`endif
      default: ;
    endcase

    if (latch_c) begin
      sample_d = 1'b1;
      sync_d   = SYNC_PATTERN;
      for (int k = 0; k < N_LANES; k++) begin
        shift_d[k] = i_word[k*WORD_W +: WORD_W];
`ifdef B2H_CRC_EN
        crc_d[k]   = '0;
`endif
      end
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q       <= '0;
      sync_q      <= '0;
      d_q         <= '0;
      frame_q     <= 1'b0;
      sample_q    <= 1'b0;
      last_q      <= 1'b0;
      frame_cnt_q <= '0;
      for (int k = 0; k < N_LANES; k++) begin
        shift_q[k] <= '0;
`ifdef B2H_CRC_EN
        crc_q[k]   <= '0;
`endif
      end
    end else begin
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      d_q         <= d_d;
      frame_q     <= frame_d;
      sample_q    <= sample_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
      for (int k = 0; k < N_LANES; k++) begin
        shift_q[k] <= shift_d[k];
`ifdef B2H_CRC_EN
        crc_q[k]   <= crc_d[k];
`endif
      end
    end
  end

  assign o_clk_s     = ~i_clk;
  assign o_d_s       = d_q;
  assign o_frame_s   = frame_q;
  assign o_sample    = sample_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: doc/b2h_frame_serializer.md
# b2h_frame_serializer

Parametrised breakout-to-host serializer, successor to the fixed 8-bit/two-lane breakout-to-host path. It snapshots a packed word of N_LANES × WORD_W bits once per frame and shifts each lane's slice out MSB-first on its own LVDS lane, preceded by a sync header. A per-lane CRC-8 trailer is optional. It sits between the user-IO / digital-input sampling logic and the LVDS output pins, clocked by the PLL system clock.

## Interface
- N_LANES, 2: number of serial data lanes (1–8).
- WORD_W, 12: payload bits per lane per frame (4–32).
- SYNC_W, 4: header bits per frame (2–8).
- SYNC_PATTERN, 4'b1010: header sent MSB-first on every lane; width SYNC_W.
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_en  in  1  run enable; sampled only at frame boundaries.
- i_word  in  N_LANES*WORD_W  payload; lane k uses bits [k*WORD_W +: WORD_W].
- o_sample  out  1  one-cycle pulse on the cycle i_word is latched.
- o_clk_s  out  1  forwarded bit clock, equal to ~i_clk.
- o_frame_s  out  1  high during header bits, low otherwise.
- o_d_s  out  N_LANES  serial data lanes, registered.
- o_frame_cnt  out  16  count of completed frames, wraps at 0xFFFF→0.

## Operation
- Frame length L = SYNC_W + WORD_W (+8 with CRC enabled). Bit counter width is ceil(log2(L)).
- States:
  - IDLE: lanes and o_frame_s are 0.
  - SYNC: SYNC_W cycles.
  - DATA: WORD_W cycles.
  - CRC: 8 cycles; exists only with CRC enabled.
- IDLE→SYNC when i_en=1. On that transition edge, i_word is latched into per-lane shift registers and o_sample pulses.
- SYNC→DATA after SYNC_W bits.
- DATA→CRC, or DATA→frame end, after WORD_W bits.
- At frame end:
  - o_frame_cnt increments.
  - If i_en=1: go straight to SYNC with no gap bit; i_word is latched and o_sample pulses on the same edge.
  - Else: go to IDLE.
- i_en deasserted mid-frame: the current frame completes in full. It is never truncated.
- All lanes send the same header. Payload is MSB-first per lane.
- i_word changes between samples are ignored. A frame always carries one coherent snapshot.

## Timing
- Reset values:
  - o_d_s = 0, o_frame_s = 0, o_sample = 0, o_frame_cnt = 0, state = IDLE, shift registers = 0.
  - o_clk_s keeps toggling during reset.
- i_reset asserted mid-frame: outputs reach reset values on the next edge, and the partial frame is abandoned. The first frame after release starts in the cycle after i_reset falls, if i_en=1.
- Latency: the first header bit appears on o_d_s in the cycle after o_sample (one register stage). o_frame_s is aligned with o_d_s.
- Continuous mode: o_sample period is exactly L cycles.
- o_frame_cnt updates on the edge where the last frame bit leaves o_d_s.
- Host samples o_d_s on the rising edge of o_clk_s, which is mid-bit.

## Configuration
- B2H_CRC_EN defined:
  - A CRC state appends 8 bits per lane after the payload.
  - Polynomial 0x07, init 0x00, no reflection, no final XOR, computed over that lane's WORD_W payload bits MSB-first.
  - CRC is sent MSB-first and o_frame_s stays low during it.
  - The CRC register is cleared at each latch.
- B2H_CRC_EN undefined: no CRC state, L = SYNC_W + WORD_W, and no CRC logic is synthesised.

## Test plan
- Reset mid-DATA, with i_en=1, N_LANES=2, WORD_W=12 -> on the next edge o_d_s=0, o_frame_s=0, o_frame_cnt=0; the next o_sample occurs 1 cycle after i_reset falls.
- i_word={12'hA5C, 12'h3F0}, continuous, no CRC:
  - Lane1 carries 1010 then 1010_0101_1100.
  - Lane0 carries 1010 then 0011_1111_0000.
  - o_sample period is 16 cycles.
- i_word toggles every cycle -> each frame's payload equals the value present on its o_sample cycle; no mixed bits.
- i_en dropped at DATA bit 3 -> the frame completes, o_frame_cnt increments by 1, and the block then idles with lanes at 0 and no further o_sample.
- B2H_CRC_EN, N_LANES=1, WORD_W=8, payload 8'hFF -> trailer 8'hF3; with payload 8'h00 -> trailer 8'h00; L=20.
- o_frame_cnt preloaded via force to 0xFFFE -> after 2 frames it reads 0x0000, with no glitch on o_d_s.
